// File: rtl/adc_controller_if.sv
// Signals between the SAR controller and the analog front end / result consumer.
// The master modport is the controller's view; the slave modport is the front end's view.
interface adc_controller_if #(
  parameter int WIDTH = 12
);
  logic             en_;
  logic             comparator;
  logic             sample_and_hold;
  logic             dac_en;
  logic             ack;
  logic [WIDTH-1:0] dac;
  logic [WIDTH-1:0] data;

  modport master (
    input  en_,
    input  comparator,
    output sample_and_hold,
    output dac_en,
    output ack,
    output dac,
    output data
  );

  modport slave (
    output en_,
    output comparator,
    input  sample_and_hold,
    input  dac_en,
    input  ack,
    input  dac,
    input  data
  );
endinterface

// File: rtl/adc_controller.sv
// SAR ADC sequencer: sample, binary-search WIDTH bits against one comparator,
// then publish the registered result with a one-cycle ack.
module adc_controller #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_,
  adc_controller_if.master bus
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAMPLE  = 2'b01,
    CONVERT = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dac_q, dac_next;
  logic [WIDTH-1:0] data_q, data_next;
  logic [WIDTH-1:0] trial;
  logic [PW-1:0]    ptr, ptr_next;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      dac_q  <= '0;
      data_q <= '0;
      ptr    <= PW'(WIDTH - 1);
    end else begin
      state  <= state_next;
      dac_q  <= dac_next;
      data_q <= data_next;
      ptr    <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    dac_next   = dac_q;
    data_next  = data_q;
    ptr_next   = ptr;
    trial      = dac_q;
    unique case (state)
      IDLE: begin
        dac_next = '0;
        if (!bus.en_) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (bus.en_) begin
          state_next = IDLE;
          dac_next   = '0;
        end else begin
          state_next = CONVERT;
          dac_next   = WIDTH'(1) << (WIDTH - 1);
          ptr_next   = PW'(WIDTH - 1);
        end
      end
      CONVERT: begin
        if (bus.en_) begin
          state_next = IDLE;
          dac_next   = '0;
        end else begin
          // Keep the trial bit only if the input is at or above the trial code.
          if (!bus.comparator) trial[ptr] = 1'b0;
          if (ptr != '0) begin
            trial[ptr - 1'b1] = 1'b1;
            ptr_next          = ptr - 1'b1;
          end else begin
            data_next  = trial;
            state_next = DONE;
          end
          dac_next = trial;
        end
      end
      DONE: begin
        if (bus.en_) begin
          state_next = IDLE;
          dac_next   = '0;
        end else begin
          state_next = SAMPLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded straight from the state register, so they cannot glitch.
  assign bus.sample_and_hold = (state == SAMPLE);
  assign bus.dac_en          = (state == CONVERT);
  assign bus.ack             = (state == DONE);
  assign bus.dac             = dac_q;
  assign bus.data            = data_q;
endmodule

// File: tb/tb_adc_controller.sv
// Bench for adc_controller: ideal comparator, a run-length timing model checked
// every cycle, plus directed conversions with hand-computed results.
module tb_adc_controller;
  localparam int W = 12;

  logic         clk    = 1'b0;
  logic         reset_ = 1'b0;
  logic [W-1:0] vin    = '0;
  int           tests  = 0;
  int           fails  = 0;

  adc_controller_if #(.WIDTH(W)) ifc ();

  assign ifc.comparator = (vin >= ifc.dac);

  adc_controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a conversion is a run of consecutive edges with en_ low. Within a run,
  // edge k leaves the controller in SAMPLE (k%14==1), CONVERT (2..13) or DONE (0).
  // The result is the input seen during conversion, published at the DONE edge.
  int           run   = 0;
  logic [W-1:0] cap   = '0;
  logic [W-1:0] mdata = '0;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      run   = 0;
      mdata = '0;
    end else if (ifc.en_) begin
      run = 0;
    end else begin
      run++;
      if (run % 14 == 3) cap = vin;
      if (run % 14 == 0) mdata = cap;
    end
  end

  always @(posedge clk) begin
    int  ph;
    logic idle;
    #2;
    ph   = run % 14;
    idle = (run == 0);
    check("cyc_sample_and_hold", 32'(ifc.sample_and_hold), 32'(!idle && ph == 1));
    check("cyc_dac_en", 32'(ifc.dac_en), 32'(!idle && ph >= 2));
    check("cyc_ack", 32'(ifc.ack), 32'(!idle && ph == 0));
    check("cyc_data", 32'(ifc.data), 32'(mdata));
    if (idle)        check("cyc_dac_idle", 32'(ifc.dac), 32'h0);
    else if (ph == 0) check("cyc_dac_done", 32'(ifc.dac), 32'(mdata));
    else if (ph == 2) check("cyc_dac_msb", 32'(ifc.dac), 32'h800);
  end

  task automatic wait_ack(output int edges);
    bool_seen: begin end
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      edges++;
      if (ifc.ack) break;
    end
    if (!ifc.ack) check("ack_timeout", 32'(ifc.ack), 32'h1);
  endtask

  task automatic convert(input logic [W-1:0] v, input string name);
    int lat;
    @(negedge clk);
    vin     = v;
    ifc.en_ = 1'b0;
    wait_ack(lat);
    $display("[TB] %s in=0x%03h data=0x%03h latency=%0d", name, v, ifc.data, lat);
    check({name, "_latency"}, 32'(lat), 32'd14);
    check({name, "_data"}, 32'(ifc.data), 32'(v));
    @(negedge clk);
    ifc.en_ = 1'b1;
    @(posedge clk);
    #2;
    check({name, "_idle"}, 32'(dut.state), 32'h0);
  endtask

  initial begin
    int           n;
    int           sum_in;
    int           sum_out;
    logic [W-1:0] v;

    ifc.en_ = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 32'(dut.state), 32'h0);
    check("rst_sh", 32'(ifc.sample_and_hold), 32'h0);
    check("rst_dac_en", 32'(ifc.dac_en), 32'h0);
    check("rst_ack", 32'(ifc.ack), 32'h0);
    check("rst_dac", 32'(ifc.dac), 32'h0);
    check("rst_data", 32'(ifc.data), 32'h0);
    $display("[TB] reset released");
    @(negedge clk);
    reset_ = 1'b1;

    convert(12'hA5C, "single");
    convert(12'h000, "zero");
    convert(12'hFFF, "full");

    // Continuous mode: input changes right after the first ack.
    @(negedge clk);
    vin     = 12'd1234;
    ifc.en_ = 1'b0;
    wait_ack(n);
    $display("[TB] cont1 in=%0d data=%0d", 1234, ifc.data);
    check("cont1_data", 32'(ifc.data), 32'd1234);
    vin = 12'd3000;
    wait_ack(n);
    $display("[TB] cont2 in=%0d data=%0d period=%0d", 3000, ifc.data, n);
    check("cont2_period", 32'(n), 32'd14);
    check("cont2_data", 32'(ifc.data), 32'd3000);

    // Oversampling: 16 more back-to-back conversions around 1000.
    sum_in  = 0;
    sum_out = 0;
    for (int i = 0; i < 16; i++) begin
      v   = W'(1000 + (i % 5) - 2);
      vin = v;
      wait_ack(n);
      $display("[TB] over%0d in=%0d data=%0d", i, v, ifc.data);
      check("over_data", 32'(ifc.data), 32'(v));
      check("over_period", 32'(n), 32'd14);
      sum_in  += int'(v);
      sum_out += int'(ifc.data);
    end
    check("over_sum", 32'(sum_out), 32'(sum_in));
    check("over_sum_lit", 32'(sum_in), 32'd15998);
    @(negedge clk);
    ifc.en_ = 1'b1;
    @(posedge clk);

    // Reset five cycles into CONVERT, asserted between clock edges.
    @(negedge clk);
    vin     = 12'h7FF;
    ifc.en_ = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    reset_ = 1'b0;
    #2;
    $display("[TB] reset mid-convert state=%0d", dut.state);
    check("mrst_state", 32'(dut.state), 32'h0);
    check("mrst_sh", 32'(ifc.sample_and_hold), 32'h0);
    check("mrst_dac_en", 32'(ifc.dac_en), 32'h0);
    check("mrst_ack", 32'(ifc.ack), 32'h0);
    check("mrst_dac", 32'(ifc.dac), 32'h0);
    check("mrst_data", 32'(ifc.data), 32'h0);
    @(negedge clk);
    ifc.en_ = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    convert(12'h3C1, "post_reset");

    // Abort five cycles into CONVERT.
    @(negedge clk);
    vin     = 12'h123;
    ifc.en_ = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("abort_in_convert", 32'(ifc.dac_en), 32'h1);
    @(negedge clk);
    ifc.en_ = 1'b1;
    @(posedge clk);
    #2;
    $display("[TB] abort state=%0d data=0x%03h", dut.state, ifc.data);
    check("abort_state", 32'(dut.state), 32'h0);
    check("abort_ack", 32'(ifc.ack), 32'h0);
    check("abort_data", 32'(ifc.data), 32'h3C1);
    check("abort_dac", 32'(ifc.dac), 32'h0);
    repeat (3) @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_controller.md
# adc_controller

Successive-approximation (SAR) ADC control FSM. It sequences an external sample-and-hold, a WIDTH-bit DAC and a single comparator to binary-search one conversion per request. It presents the result on a stable, registered `data` bus with a one-cycle `ack` pulse. It sits between the analog front end (S/H, DAC, comparator) and the digital consumer that reads `data`.

## Interface
- `WIDTH`, default 12: resolution in bits of the DAC code and of the result.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_` input 1: asynchronous, active-low reset.
- `en_` input 1: active-low conversion enable/request.
  - Held low: back-to-back conversions.
  - Driven high: abort or stop.
- `comparator` input 1: 1 when analog input ≥ current DAC voltage (`dac` code); combinational from `dac`.
- `sample_and_hold` output 1: high to make the external S/H track; low to hold.
- `dac_en` output 1: high while the DAC trial code is valid (CONVERT).
- `ack` output 1: one-cycle pulse; the new result is valid on `data`.
- `dac` output WIDTH: DAC trial code.
- `data` output WIDTH: last completed conversion result (registered).

## Operation
- Internal register `state` [1:0]: IDLE=2'b00, SAMPLE=2'b01, CONVERT=2'b10, DONE=2'b11.
- Reset (`reset_`=0) takes effect immediately, without waiting for a clock edge:
  - `state`=IDLE.
  - `dac`=0, `data`=0, bit pointer=WIDTH-1.
  - `sample_and_hold`=0, `dac_en`=0, `ack`=0.
- IDLE:
  - Outputs low; `dac`=0.
  - `en_`=0 → SAMPLE; otherwise stay.
- SAMPLE (1 cycle):
  - `sample_and_hold`=1.
  - `en_`=1 → IDLE.
  - Otherwise → CONVERT, loading `dac`=1<<(WIDTH-1) and pointer=WIDTH-1.
- CONVERT (WIDTH cycles): `dac_en`=1, `sample_and_hold`=0. On each edge with `en_`=0:
  - If `comparator`=0, clear `dac[ptr]`.
  - If ptr>0: set `dac[ptr-1]`, decrement ptr, stay in CONVERT.
  - If ptr==0: load `data` with the final code (after the bit-0 decision) → DONE.
  - `en_`=1 on any CONVERT edge → IDLE. `dac` returns to 0; `data` is unchanged; no `ack`.
- DONE (1 cycle):
  - `ack`=1 (decoded from `state`, so it is glitch-free); `dac` holds the result.
  - `en_`=0 → SAMPLE (continuous mode).
  - `en_`=1 → IDLE.
- Result: with an ideal comparator (input ≥ `dac`), `data` equals the integer input code exactly, for 0 … 2^WIDTH−1.
- `data` changes only on the edge entering DONE. It is stable for the whole following conversion, including across aborts.

## Timing
- Edge E0: first edge with `en_`=0 in IDLE → SAMPLE.
- E1 → CONVERT, MSB trial.
- E2 … E(WIDTH+1): bit decisions MSB..LSB, one per edge.
- At E(WIDTH+1): `data` loaded, `ack` rises.
- Request-to-`ack` latency: WIDTH+2 edges after IDLE; 14 for WIDTH=12.
- Continuous throughput: one result every WIDTH+2 cycles (SAMPLE + WIDTH CONVERT + DONE).
- `ack` high exactly one cycle per conversion; it returns low before the next conversion, so each result produces a distinct rising edge.
- The comparator must settle within one cycle of a `dac` change.
- The analog input may change any time outside CONVERT; the S/H tracks only in SAMPLE.
- Abort latency: one edge after `en_` is seen high, from SAMPLE, CONVERT or DONE.
- Reset mid-conversion: `state`==IDLE within simulation delta (checked 2 ns after assertion). The first request after release behaves as from power-up.

## Test plan
- Single conversion, WIDTH=12, input 0xA5C: pull `en_` low, wait for `ack` → `data`=0xA5C at the `ack` rise, 14 edges after request; release `en_` → IDLE.
- Boundaries: inputs 0x000 and 0xFFF → `data`=0x000 and 0xFFF respectively.
- Continuous: hold `en_` low with input 1234, then change to 3000 right after the first `ack`.
  - First `ack` → 1234.
  - `data` stays 1234 until the second `ack`.
  - Second `ack` → 3000; `ack` period 14 cycles.
- Oversampling: 16 back-to-back conversions of 1000 ± {−2..+2} → each `data` equals its input; the sum of the 16 results equals the sum of the inputs.
- Reset mid-CONVERT: assert `reset_` 5 cycles into a conversion → `state`=00 and all outputs 0 within 2 ns. After release, a request with input 0x3C1 → `data`=0x3C1.
- Abort: drive `en_` high 5 cycles into CONVERT → `state`=00 one edge later, no `ack`, `data` unchanged.
